arp_step_scheduler: RTL and testbench
=====================================

ARP_STEP_SCHEDULER -- requirements
Module: arp_step_scheduler

Interface
REQ-001 Parameter CLK_FREQ, 50_000_000, clock frequency in Hz; CLK_FREQ*60 SHALL be divisible by 24.
REQ-002 Parameter ACC_W, 32, phase accumulator width.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset.
REQ-005 run  in  1  level; high = arpeggiator active (dispatcher in ARPEGGIATOR mode with notes held).
REQ-006 tempo  in  7  MIDI data value; BPM = tempo + 60 (60..187).
REQ-007 arp_rate  in  3  arp_rate_t encoding (QUARTER=0 .. THIRTY_SECOND_TRIPLET=7).
REQ-008 arp_rhythm  in  2  arp_rhythm_t encoding (O=0, OXO=1, OXXO=2, RANDOM=3).
REQ-009 ext_sync  in  1  select external tick source (used only with ARP_EXT_SYNC_EN).
REQ-010 ext_tick  in  1  one-cycle 24-PPQN pulse from MIDI clock decoder (used only with ARP_EXT_SYNC_EN).
REQ-011 step_ready  in  1  consumer accepts step when step_valid && step_ready.
REQ-012 step_valid  out  1  step pending.
REQ-013 step_play  out  1  1 = play note, 0 = rest; stable while step_valid.
REQ-014 step_pos  out  2  rhythm-pattern position of pending step.
REQ-015 tick  out  1  one-cycle pulse per active 24-PPQN tick.
REQ-016 overrun  out  1  sticky: a step was dropped because previous step was unaccepted.

Function
REQ-017 FSM states IDLE, RUN; IDLE->RUN when run=1; RUN->IDLE when run=0; reset -> IDLE.
REQ-018 Internal tick: each RUN cycle acc += BPM (zero-extended); when acc+BPM >= CLK_FREQ*60/24, acc <= acc+BPM-threshold and tick=1 that cycle (remainder preserved, no drift).
REQ-019 Tick divider counts ticks per step: rate 0..7 -> 24,12,6,3,16,8,4,2.
REQ-020 arp_rate SHALL be latched at each step boundary and on IDLE->RUN; mid-step changes take effect at next step; tempo changes take effect next cycle.
REQ-021 On IDLE->RUN transition cycle: acc, divider, pattern position cleared; first step (pos 0) issued, step_valid=1 next cycle.
REQ-022 Step issued when divider reaches latched count (divider then restarts at 0).
REQ-023 Rhythm: O -> always play, pos stays 0; OXO -> 3-step cycle play,rest,play; OXXO -> 4-step cycle play,rest,rest,play; RANDOM -> play = LFSR bit, pos stays 0.
REQ-024 LFSR: 16-bit maximal (taps 16,14,13,11), seed 16'hACE1 at reset, advances once per issued step, never all-zero.
REQ-025 Pattern position SHALL wrap to 0 after last element; arp_rhythm change resets position to 0 at next step.
REQ-026 step_valid held with step_play/step_pos stable until handshake; cleared the cycle after acceptance.
REQ-027 New step arriving while step_valid=1 and step_ready=0: new step dropped, overrun<=1; if step_ready=1 same cycle, new step replaces it with no overrun.
REQ-028 RUN->IDLE: step_valid cleared next cycle, acc/divider frozen and cleared; overrun retained.
REQ-029 overrun cleared only by reset.

Reset
REQ-030 rst_n=0 at a clock edge: state IDLE, acc=0, divider=0, pos=0, LFSR=16'hACE1, step_valid=0, step_play=0, step_pos=0, tick=0, overrun=0, regardless of in-progress step.

Configuration
REQ-031 Macro ARP_EXT_SYNC_EN: defined -> when ext_sync=1 the tick source is ext_tick (accumulator held at 0), else internal; undefined -> internal accumulator always, ext_sync/ext_tick ignored.

Verification (CLK_FREQ=2400, threshold 6000)
REQ-032 tempo=0, rate=0, rhythm=0, step_ready=1, run rises -> step at cycle 1, tick every 100 cycles, next steps every 2400 cycles, all step_play=1.
REQ-033 tempo=0, rate=3, rhythm=1 -> step every 300 cycles, step_play sequence 1,0,1,1,0,1; rhythm=2 -> 1,0,0,1,1,0,0,1.
REQ-034 step_ready=0 for 2 steps at rate=7 -> first step held, overrun=1 on second; step_ready=1 -> accepted, step_valid=0 next cycle.
REQ-035 arp_rate 0->1 changed 1000 cycles into step -> current step still ends at 2400, subsequent at 1200 intervals.
REQ-036 rst_n=0 mid-RUN with step pending -> all outputs 0 next cycle; run still 1 after release -> first step one cycle after reset deasserts.
REQ-037 With ARP_EXT_SYNC_EN, ext_sync=1, rate=7, ext_tick every 10 cycles -> step every 20 cycles, tick mirrors ext_tick; macro undefined -> ext_tick ignored.

Source files
------------

// File: rtl/arp_step_scheduler.sv
// Arpeggiator step scheduler: BPM phase accumulator -> 24-PPQN ticks -> rhythm-patterned steps.
// Build option ARP_EXT_SYNC_EN: when defined, ext_sync=1 replaces the internal tick source with ext_tick.
module arp_step_scheduler #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int ACC_W    = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [6:0] tempo,
  input  logic [2:0] arp_rate,
  input  logic [1:0] arp_rhythm,
  input  logic       ext_sync,
  input  logic       ext_tick,
  input  logic       step_ready,
  output logic       step_valid,
  output logic       step_play,
  output logic [1:0] step_pos,
  output logic       tick,
  output logic       overrun
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam longint          THR_L   = (longint'(CLK_FREQ) * 64'sd60) / 64'sd24;
  localparam logic [ACC_W:0]  THR     = (ACC_W+1)'(THR_L);
  localparam logic [ACC_W:0]  BPM_OFS = (ACC_W+1)'(7'd60);

  function automatic logic [4:0] ticks_per_step(input logic [2:0] rate);
    case (rate)
      3'd0:    ticks_per_step = 5'd24;
      3'd1:    ticks_per_step = 5'd12;
      3'd2:    ticks_per_step = 5'd6;
      3'd3:    ticks_per_step = 5'd3;
      3'd4:    ticks_per_step = 5'd16;
      3'd5:    ticks_per_step = 5'd8;
      3'd6:    ticks_per_step = 5'd4;
      default: ticks_per_step = 5'd2;
    endcase
  endfunction

  function automatic logic [1:0] last_pos(input logic [1:0] rhy);
    case (rhy)
      2'd1:    last_pos = 2'd2;
      2'd2:    last_pos = 2'd3;
      default: last_pos = 2'd0;
    endcase
  endfunction

  function automatic logic pattern_play(input logic [1:0] rhy, input logic [1:0] pos, input logic rnd);
    case (rhy)
      2'd1:    pattern_play = (pos != 2'd1);
      2'd2:    pattern_play = (pos == 2'd0) || (pos == 2'd3);
      2'd3:    pattern_play = rnd;
      default: pattern_play = 1'b1;
    endcase
  endfunction

  // Right-shifting form of the x^16+x^14+x^13+x^11+1 maximal-length LFSR
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    lfsr_next = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [4:0]        div_q, div_d;
  logic [2:0]        rate_q, rate_d;
  logic [1:0]        rhythm_q, rhythm_d;
  logic [1:0]        pos_q, pos_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic              valid_q, valid_d;
  logic              play_q, play_d;
  logic [1:0]        spos_q, spos_d;
  logic              tick_q, tick_d;
  logic              overrun_q, overrun_d;
  logic              issue_s, first_s, tick_s, ext_mode_s, ext_tick_s;
  logic [ACC_W:0]    sum_s;
  logic [1:0]        new_pos_s;

`ifdef ARP_EXT_SYNC_EN
  assign ext_mode_s = ext_sync;
  assign ext_tick_s = ext_tick;
`else
  logic unused_ext_s;
  assign unused_ext_s = ext_sync ^ ext_tick;
  assign ext_mode_s   = 1'b0;
  assign ext_tick_s   = 1'b0;
`endif

  // Next-state: FSM, tick generation, step divider, pattern and output handshake
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    div_d     = div_q;
    rate_d    = rate_q;
    rhythm_d  = rhythm_q;
    pos_d     = pos_q;
    lfsr_d    = lfsr_q;
    valid_d   = valid_q;
    play_d    = play_q;
    spos_d    = spos_q;
    overrun_d = overrun_q;
    issue_s   = 1'b0;
    first_s   = 1'b0;
    tick_s    = 1'b0;
    new_pos_s = 2'd0;
    sum_s     = {1'b0, acc_q} + {{(ACC_W-6){1'b0}}, tempo} + BPM_OFS;

    case (state_q)
      IDLE: begin
        acc_d = {ACC_W{1'b0}};
        div_d = 5'd0;
        if (run) begin
          state_d = RUN;
          rate_d  = arp_rate;
          issue_s = 1'b1;
          first_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (!run) begin
          state_d = IDLE;
          acc_d   = {ACC_W{1'b0}};
          div_d   = 5'd0;
        end else begin
          // Subtracting the threshold keeps the remainder, so tick spacing never drifts
          if (ext_mode_s) begin
            acc_d  = {ACC_W{1'b0}};
            tick_s = ext_tick_s;
          end else if (sum_s >= THR) begin
            acc_d  = ACC_W'(sum_s - THR);
            tick_s = 1'b1;
          end else begin
            acc_d  = sum_s[ACC_W-1:0];
          end
          if (tick_s && (div_q + 5'd1 == ticks_per_step(rate_q))) begin
            div_d   = 5'd0;
            rate_d  = arp_rate;
            issue_s = 1'b1;
          end else if (tick_s) begin
            div_d   = div_q + 5'd1;
          end else begin
            div_d   = div_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (first_s || (arp_rhythm != rhythm_q) || (pos_q == last_pos(rhythm_q))) begin
      new_pos_s = 2'd0;
    end else begin
      new_pos_s = pos_q + 2'd1;
    end

    if (issue_s) begin
      rhythm_d = arp_rhythm;
      pos_d    = new_pos_s;
      lfsr_d   = lfsr_next(lfsr_q);
    end else begin
      lfsr_d   = lfsr_q;
    end

    // A pending unaccepted step wins over a new one; the new one is dropped
    if ((state_q == RUN) && !run) begin
      valid_d = 1'b0;
    end else if (issue_s && valid_q && !step_ready) begin
      overrun_d = 1'b1;
    end else if (issue_s) begin
      valid_d = 1'b1;
      play_d  = pattern_play(arp_rhythm, new_pos_s, lfsr_q[0]);
      spos_d  = new_pos_s;
    end else if (valid_q && step_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    tick_d = tick_s;
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= {ACC_W{1'b0}};
      div_q     <= 5'd0;
      rate_q    <= 3'd0;
      rhythm_q  <= 2'd0;
      pos_q     <= 2'd0;
      lfsr_q    <= 16'hACE1;
      valid_q   <= 1'b0;
      play_q    <= 1'b0;
      spos_q    <= 2'd0;
      tick_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      div_q     <= div_d;
      rate_q    <= rate_d;
      rhythm_q  <= rhythm_d;
      pos_q     <= pos_d;
      lfsr_q    <= lfsr_d;
      valid_q   <= valid_d;
      play_q    <= play_d;
      spos_q    <= spos_d;
      tick_q    <= tick_d;
      overrun_q <= overrun_d;
    end
  end

  assign step_valid = valid_q;
  assign step_play  = play_q;
  assign step_pos   = spos_q;
  assign tick       = tick_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_arp_step_scheduler.sv
// Self-checking bench for arp_step_scheduler (CLK_FREQ=2400, tick threshold 6000) with a behavioural model.
module tb_arp_step_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic [6:0] tempo = 7'd0;
  logic [2:0] arp_rate = 3'd0;
  logic [1:0] arp_rhythm = 2'd0;
  logic       ext_sync = 1'b0;
  logic       ext_tick = 1'b0;
  logic       step_ready = 1'b1;
  logic       step_valid, step_play, tick, overrun;
  logic [1:0] step_pos;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  arp_step_scheduler #(.CLK_FREQ(2400), .ACC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .tempo(tempo), .arp_rate(arp_rate),
    .arp_rhythm(arp_rhythm), .ext_sync(ext_sync), .ext_tick(ext_tick),
    .step_ready(step_ready), .step_valid(step_valid), .step_play(step_play),
    .step_pos(step_pos), .tick(tick), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Reference model state
  int          steps_tbl [8] = '{24, 12, 6, 3, 16, 8, 4, 2};
  int          pat_len   [4] = '{1, 3, 4, 1};
  bit          pat [4][4]    = '{'{1,0,0,0}, '{1,0,1,0}, '{1,0,0,1}, '{0,0,0,0}};
  bit          m_active = 1'b0;
  int          m_acc = 0, m_cnt = 0, m_len = 24;
  logic [1:0]  m_ppos = 2'd0, m_rhy = 2'd0, m_pos = 2'd0;
  logic [15:0] m_lfsr = 16'hACE1;
  logic        m_valid = 1'b0, m_play = 1'b0, m_tick = 1'b0, m_overrun = 1'b0;

  task automatic model_edge();
    bit issue = 1'b0;
    bit first = 1'b0;
    bit t = 1'b0;
    bit vold = m_valid;
    bit p;
    if (!rst_n) begin
      m_active = 1'b0; m_acc = 0; m_cnt = 0; m_ppos = 2'd0; m_rhy = 2'd0; m_pos = 2'd0;
      m_lfsr = 16'hACE1; m_valid = 1'b0; m_play = 1'b0; m_tick = 1'b0; m_overrun = 1'b0;
      return;
    end
    if (!m_active) begin
      m_tick = 1'b0;
      if (run) begin
        m_active = 1'b1; m_acc = 0; m_cnt = 0; m_len = steps_tbl[arp_rate];
        issue = 1'b1; first = 1'b1;
      end
    end else if (!run) begin
      m_active = 1'b0; m_acc = 0; m_cnt = 0; m_valid = 1'b0; m_tick = 1'b0;
    end else begin
`ifdef ARP_EXT_SYNC_EN
      if (ext_sync) begin
        m_acc = 0;
        t = ext_tick;
      end else begin
        m_acc += int'(tempo) + 60;
        if (m_acc >= 6000) begin m_acc -= 6000; t = 1'b1; end
      end
`else
      m_acc += int'(tempo) + 60;
      if (m_acc >= 6000) begin m_acc -= 6000; t = 1'b1; end
`endif
      m_tick = t;
      if (t) begin
        m_cnt++;
        if (m_cnt == m_len) begin
          m_cnt = 0; m_len = steps_tbl[arp_rate]; issue = 1'b1;
        end
      end
    end
    if (issue) begin
      if (first || arp_rhythm != m_rhy) m_ppos = 2'd0;
      else m_ppos = 2'((int'(m_ppos) + 1) % pat_len[arp_rhythm]);
      m_rhy = arp_rhythm;
      p = (arp_rhythm == 2'd3) ? m_lfsr[0] : pat[arp_rhythm][m_ppos];
      m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
      if (vold && !step_ready) m_overrun = 1'b1;
      else begin m_valid = 1'b1; m_play = p; m_pos = m_ppos; end
    end else if (vold && step_ready) begin
      m_valid = 1'b0;
    end
  endtask

  // One clock: model follows the DUT edge, outputs are then sampled at the falling edge
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0; ext_sync = 1'b0; ext_tick = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b1; step_ready = 1'b1;
    repeat (2) cycle();
    checks++;
    if ({step_valid, step_play, step_pos, tick, overrun} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b want %b", {step_valid, step_play, step_pos, tick, overrun}, 6'b0);
    end
    do_reset();
    cycle();
    checks++;
    if ({step_valid, tick, overrun} !== 3'b0) begin
      errors++;
      $display("FAIL idle_outputs got %b want %b", {step_valid, tick, overrun}, 3'b0);
    end
  endtask

  task automatic test_basic();
    int last_tick = -1;
    int last_step;
    do_reset();
    tempo = 7'd0; arp_rate = 3'd0; arp_rhythm = 2'd0; step_ready = 1'b1; run = 1'b1;
    cycle();
    last_step = cyc;
    checks++;
    if ({step_valid, step_play, step_pos} !== 4'b1100) begin
      errors++;
      $display("FAIL first_step got %b want %b", {step_valid, step_play, step_pos}, 4'b1100);
    end
    repeat (5000) begin
      cycle();
      checks++;
      if ({step_valid, tick, overrun} !== {m_valid, m_tick, m_overrun}) begin
        errors++;
        $display("FAIL basic_model cyc=%0d got %b want %b", cyc, {step_valid, tick, overrun}, {m_valid, m_tick, m_overrun});
      end
      if (tick) begin
        if (last_tick >= 0) begin
          checks++;
          if (cyc - last_tick != 100) begin
            errors++;
            $display("FAIL tick_period got %0d want %0d", cyc - last_tick, 100);
          end
        end
        last_tick = cyc;
      end
      if (step_valid) begin
        checks++;
        if (cyc - last_step != 2400 || step_play !== 1'b1) begin
          errors++;
          $display("FAIL quarter_step got gap=%0d play=%b want gap=2400 play=1", cyc - last_step, step_play);
        end
        last_step = cyc;
      end
    end
  endtask

  task automatic test_rhythm();
    bit exp_seq [2][8] = '{'{1,0,1,1,0,1,0,0}, '{1,0,0,1,1,0,0,1}};
    int gtime [8];
    bit gplay [8];
    logic [1:0] gpos [8];
    for (int s = 0; s < 2; s++) begin
      int n = 0;
      int guard = 0;
      int len = (s == 0) ? 6 : 8;
      int plen = (s == 0) ? 3 : 4;
      do_reset();
      tempo = 7'd0; arp_rate = 3'd3; arp_rhythm = (s == 0) ? 2'd1 : 2'd2; step_ready = 1'b1; run = 1'b1;
      while (n < len && guard < 3000) begin
        cycle();
        guard++;
        if (step_valid) begin
          gtime[n] = cyc; gplay[n] = step_play; gpos[n] = step_pos; n++;
        end
      end
      checks++;
      if (n != len) begin
        errors++;
        $display("FAIL rhythm_timeout got %0d steps want %0d", n, len);
      end
      for (int i = 0; i < n; i++) begin
        checks++;
        if (gplay[i] !== exp_seq[s][i] || gpos[i] !== 2'(i % plen)) begin
          errors++;
          $display("FAIL rhythm%0d_step%0d got play=%b pos=%0d want play=%b pos=%0d", s, i, gplay[i], gpos[i], exp_seq[s][i], i % plen);
        end
        if (i > 0) begin
          checks++;
          if (gtime[i] - gtime[i-1] != 300) begin
            errors++;
            $display("FAIL rhythm_period got %0d want %0d", gtime[i] - gtime[i-1], 300);
          end
        end
      end
    end
  endtask

  task automatic test_overrun();
    int c0;
    int guard = 0;
    do_reset();
    tempo = 7'd0; arp_rate = 3'd7; arp_rhythm = 2'd0; step_ready = 1'b0; run = 1'b1;
    cycle();
    c0 = cyc;
    checks++;
    if ({step_valid, overrun} !== 2'b10) begin
      errors++;
      $display("FAIL overrun_first got %b want %b", {step_valid, overrun}, 2'b10);
    end
    while (!overrun && guard < 400) begin cycle(); guard++; end
    checks++;
    if (cyc - c0 != 200 || {step_valid, step_play, step_pos} !== 4'b1100) begin
      errors++;
      $display("FAIL overrun_set got t=%0d out=%b want t=200 out=1100", cyc - c0, {step_valid, step_play, step_pos});
    end
    step_ready = 1'b1;
    cycle();
    checks++;
    if ({step_valid, overrun} !== 2'b01) begin
      errors++;
      $display("FAIL overrun_accept got %b want %b", {step_valid, overrun}, 2'b01);
    end
  endtask

  task automatic test_rate_change();
    int c0;
    int n = 0;
    int guard = 0;
    int t [2];
    do_reset();
    tempo = 7'd0; arp_rate = 3'd0; arp_rhythm = 2'd0; step_ready = 1'b1; run = 1'b1;
    cycle();
    c0 = cyc;
    repeat (1000) cycle();
    arp_rate = 3'd1;
    while (n < 2 && guard < 4000) begin
      cycle();
      guard++;
      if (step_valid) begin t[n] = cyc - c0; n++; end
    end
    checks++;
    if (n != 2 || t[0] != 2400 || t[1] != 3600) begin
      errors++;
      $display("FAIL rate_change got n=%0d t0=%0d t1=%0d want n=2 t0=2400 t1=3600", n, t[0], t[1]);
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    do_reset();
    tempo = 7'd0; arp_rate = 3'd7; arp_rhythm = 2'd0; step_ready = 1'b0; run = 1'b1;
    cycle();
    while (!overrun && guard < 400) begin cycle(); guard++; end
    rst_n = 1'b0;
    cycle();
    checks++;
    if ({step_valid, step_play, step_pos, tick, overrun} !== 6'b0) begin
      errors++;
      $display("FAIL reset_mid got %b want %b", {step_valid, step_play, step_pos, tick, overrun}, 6'b0);
    end
    rst_n = 1'b1;
    cycle();
    checks++;
    if ({step_valid, step_pos, overrun} !== 4'b1000) begin
      errors++;
      $display("FAIL restart_step got %b want %b", {step_valid, step_pos, overrun}, 4'b1000);
    end
  endtask

  task automatic test_random();
    do_reset();
    run = 1'b1;
    tempo = 7'($urandom_range(0, 127));
    for (int i = 0; i < 30000; i++) begin
      if ($urandom_range(0, 199) == 0) tempo = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 149) == 0) arp_rate = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 299) == 0) arp_rhythm = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2999) == 0) run = ~run;
      else if (!run && $urandom_range(0, 99) == 0) run = 1'b1;
      if ($urandom_range(0, 999) == 0) ext_sync = ~ext_sync;
      ext_tick = (i % 10 == 0);
      step_ready = ($urandom_range(0, 9) < 7);
      rst_n = ($urandom_range(0, 7999) != 0);
      cycle();
      checks++;
      if ({step_valid, tick, overrun} !== {m_valid, m_tick, m_overrun}) begin
        errors++;
        $display("FAIL random_ctrl cyc=%0d got %b want %b", cyc, {step_valid, tick, overrun}, {m_valid, m_tick, m_overrun});
      end
      if (m_valid) begin
        checks++;
        if ({step_play, step_pos} !== {m_play, m_pos}) begin
          errors++;
          $display("FAIL random_step cyc=%0d got %b want %b", cyc, {step_play, step_pos}, {m_play, m_pos});
        end
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_rhythm();
    test_overrun();
    test_rate_change();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
